// File: rtl/verificador_funcoes.sv
// Registered function-code equality checker with sticky mismatch alarm.
// Optional XOR capture on alarm entry: define VERIFICADOR_DIF_CAPTURA_EN.
module verificador_funcoes #(
  parameter int LARGURA = 3,
  parameter int LIMITE  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] func_a,
  input  logic [LARGURA-1:0] func_b,
  input  logic               amostra_valida,
  input  logic               limpa_alarme,
  output logic               diferenca,
  output logic [1:0]         estado,
  output logic               alarme,
  output logic [7:0]         cont_dif,
  output logic [LARGURA-1:0] diff_captura
);

  typedef enum logic [1:0] {
    IGUAL    = 2'b00,
    SUSPEITO = 2'b01,
    ALARME   = 2'b10
  } est_t;

  localparam logic [7:0] LIM = 8'(LIMITE);

  est_t               est_q;
  est_t               est_d;
  logic [7:0]         cont_q;
  logic [7:0]         cont_d;
  logic [7:0]         cont_inc;
  logic               dif_q;
  logic [LARGURA-1:0] x;
  logic               mis;
  logic               entra;

  assign x        = func_a ^ func_b;
  assign mis      = |x;
  assign cont_inc = cont_q + 8'd1;

  always_comb begin
    est_d  = est_q;
    cont_d = cont_q;
    entra  = 1'b0;
    if (limpa_alarme) begin
      est_d  = IGUAL;
      cont_d = 8'd0;
    end else if (amostra_valida) begin
      unique case (1'b1)
        est_q == IGUAL: begin
          if (mis) begin
            cont_d = 8'd1;
            if (LIM == 8'd1) begin
              est_d = ALARME;
              entra = 1'b1;
            end else begin
              est_d = SUSPEITO;
            end
          end else begin
            cont_d = 8'd0;
          end
        end
        est_q == SUSPEITO: begin
          if (mis) begin
            cont_d = cont_inc;
            if (cont_inc == LIM) begin
              est_d = ALARME;
              entra = 1'b1;
            end
          end else begin
            est_d  = IGUAL;
            cont_d = 8'd0;
          end
        end
        default: begin
          est_d  = est_q;
          cont_d = cont_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      est_q  <= IGUAL;
      cont_q <= 8'd0;
      dif_q  <= 1'b0;
      alarme <= 1'b0;
    end else begin
      est_q  <= est_d;
      cont_q <= cont_d;
      alarme <= (est_d == ALARME);
      if (amostra_valida)
        dif_q <= mis;
    end
  end

`ifdef VERIFICADOR_DIF_CAPTURA_EN
  logic [LARGURA-1:0] cap_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cap_q <= '0;
    else if (limpa_alarme)
      cap_q <= '0;
    else if (entra)
      cap_q <= x;
  end

  assign diff_captura = cap_q;
`else
  logic unused_entra;

  assign unused_entra = entra;
  assign diff_captura = '0;
`endif

  assign diferenca = dif_q;
  assign estado    = est_q;
  assign cont_dif  = cont_q;

endmodule
